// File: rtl/seg_instruction_decode_hz_pkg.sv
// Shared MIPS decode definitions: opcodes, control bus layout, ALU-op encodings
// and the opcode-to-control lookup used by the ID stage.
package seg_instruction_decode_hz_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;

    // Bit positions inside the control buses
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;
    localparam int MEM_BRANCH    = 2;
    localparam int MEM_READ      = 1;
    localparam int MEM_WRITE     = 0;
    localparam int EXC_REG_DST   = 2;
    localparam int EXC_ALU_SRC   = 1;
    localparam int EXC_LUI       = 0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_IMM   = 2'b11
    } aluop_e;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] mem;
        logic [2:0] exc;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: c = '{wb: 2'b10, mem: 3'b000, exc: 3'b100, alu_op: ALUOP_RTYPE};
            OP_LW:    c = '{wb: 2'b11, mem: 3'b010, exc: 3'b010, alu_op: ALUOP_ADD};
            OP_SW:    c = '{wb: 2'b00, mem: 3'b001, exc: 3'b010, alu_op: ALUOP_ADD};
            OP_BEQ,
            OP_BNE:   c = '{wb: 2'b00, mem: 3'b100, exc: 3'b000, alu_op: ALUOP_SUB};
            OP_ADDI,
            OP_SLTI,
            OP_ANDI,
            OP_ORI,
            OP_XORI:  c = '{wb: 2'b10, mem: 3'b000, exc: 3'b010, alu_op: ALUOP_IMM};
            OP_LUI:   c = '{wb: 2'b10, mem: 3'b000, exc: 3'b011, alu_op: ALUOP_IMM};
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/seg_instruction_decode_hz_reg_bank.sv
// General-purpose register bank: two read ports with write-first bypass,
// one write port, reg 0 hardwired to zero, synchronous clear.
module seg_instruction_decode_hz_reg_bank #(
    parameter int LEN     = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [LEN-1:0]     i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr_1,
    input  logic [NB_ADDR-1:0] i_rd_addr_2,
    output logic [LEN-1:0]     o_rd_data_1,
    output logic [LEN-1:0]     o_rd_data_2
);

    localparam int DEPTH = 2 ** NB_ADDR;

    logic [LEN-1:0] r_mem [DEPTH];

    // Storage: cleared on reset, reg 0 never written
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port 1 with write-first bypass
    always_comb begin
        o_rd_data_1 = r_mem[i_rd_addr_1];
        if (i_rd_addr_1 == '0) begin
            o_rd_data_1 = '0;
        end else if (i_wr_en && (i_wr_addr == i_rd_addr_1)) begin
            o_rd_data_1 = i_wr_data;
        end else begin
            o_rd_data_1 = r_mem[i_rd_addr_1];
        end
    end

    // Read port 2 with write-first bypass
    always_comb begin
        o_rd_data_2 = r_mem[i_rd_addr_2];
        if (i_rd_addr_2 == '0) begin
            o_rd_data_2 = '0;
        end else if (i_wr_en && (i_wr_addr == i_rd_addr_2)) begin
            o_rd_data_2 = i_wr_data;
        end else begin
            o_rd_data_2 = r_mem[i_rd_addr_2];
        end
    end

endmodule

// File: rtl/seg_instruction_decode_hz.sv
// MIPS instruction-decode stage: register bank, control decode, immediate
// extension, load-use stall / branch flush, and the ID/EX pipeline register.
module seg_instruction_decode_hz
    import seg_instruction_decode_hz_pkg::*;
#(
    parameter int LEN        = 32,
    parameter int NB_ADDR    = 5,
    parameter int NB_OPCODE  = 6,
    parameter int NB_WB_BUS  = 2,
    parameter int NB_MEM_BUS = 3,
    parameter int NB_EXC_BUS = 3,
    parameter int NB_ALUOP   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [LEN-1:0]        i_instruc,
    input  logic [LEN-1:0]        i_pc_plus4,
    input  logic                  i_wb_en,
    input  logic [NB_ADDR-1:0]    i_wb_addr,
    input  logic [LEN-1:0]        i_wb_data,
    input  logic                  i_ex_mem_read,
    input  logic [NB_ADDR-1:0]    i_ex_rt,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [LEN-1:0]        o_read_data_1,
    output logic [LEN-1:0]        o_read_data_2,
    output logic [LEN-1:0]        o_addr_ext,
    output logic [LEN-1:0]        o_branch_target,
    output logic [NB_ADDR-1:0]    o_rs,
    output logic [NB_ADDR-1:0]    o_rt,
    output logic [NB_ADDR-1:0]    o_rd,
    output logic [NB_WB_BUS-1:0]  o_wb_bus,
    output logic [NB_MEM_BUS-1:0] o_mem_bus,
    output logic [NB_EXC_BUS-1:0] o_exc_bus,
    output logic [NB_ALUOP-1:0]   o_alu_op,
    output logic [NB_OPCODE-1:0]  o_funct
);

    logic [NB_OPCODE-1:0] w_opcode;
    logic [NB_OPCODE-1:0] w_funct;
    logic [NB_ADDR-1:0]   w_rs;
    logic [NB_ADDR-1:0]   w_rt;
    logic [NB_ADDR-1:0]   w_rd;
    logic [15:0]          w_imm;
    logic [LEN-1:0]       w_sext;
    logic [LEN-1:0]       w_addr_ext;
    logic [LEN-1:0]       w_branch_target;
    logic [LEN-1:0]       w_rd_data_1;
    logic [LEN-1:0]       w_rd_data_2;
    logic                 w_hazard;
    ctrl_t                w_ctrl;

    logic                  r_valid;
    logic [LEN-1:0]        r_read_data_1;
    logic [LEN-1:0]        r_read_data_2;
    logic [LEN-1:0]        r_addr_ext;
    logic [LEN-1:0]        r_branch_target;
    logic [NB_ADDR-1:0]    r_rs;
    logic [NB_ADDR-1:0]    r_rt;
    logic [NB_ADDR-1:0]    r_rd;
    logic [NB_WB_BUS-1:0]  r_wb_bus;
    logic [NB_MEM_BUS-1:0] r_mem_bus;
    logic [NB_EXC_BUS-1:0] r_exc_bus;
    logic [NB_ALUOP-1:0]   r_alu_op;
    logic [NB_OPCODE-1:0]  r_funct;

    assign w_opcode = i_instruc[31:26];
    assign w_rs     = i_instruc[25:21];
    assign w_rt     = i_instruc[20:16];
    assign w_rd     = i_instruc[15:11];
    assign w_imm    = i_instruc[15:0];
    assign w_funct  = i_instruc[5:0];

    seg_instruction_decode_hz_reg_bank #(
        .LEN     (LEN),
        .NB_ADDR (NB_ADDR)
    ) u_reg_bank (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_en     (i_wb_en),
        .i_wr_addr   (i_wb_addr),
        .i_wr_data   (i_wb_data),
        .i_rd_addr_1 (w_rs),
        .i_rd_addr_2 (w_rt),
        .o_rd_data_1 (w_rd_data_1),
        .o_rd_data_2 (w_rd_data_2)
    );

    // Control decode, gated off for empty IF/ID slots
    always_comb begin
        w_ctrl = '0;
        if (i_valid) begin
            w_ctrl = decode_ctrl(w_opcode);
        end else begin
            w_ctrl = '0;
        end
    end

    // Immediate extension selected by opcode
    always_comb begin
        w_sext     = {{(LEN-16){w_imm[15]}}, w_imm};
        w_addr_ext = w_sext;
        if (w_opcode == OP_LUI) begin
            w_addr_ext = {w_imm, 16'h0000};
        end else if (is_zero_ext(w_opcode)) begin
            w_addr_ext = {{(LEN-16){1'b0}}, w_imm};
        end else begin
            w_addr_ext = w_sext;
        end
    end

    assign w_branch_target = i_pc_plus4 + (w_sext << 2);

    // Load-use hazard: load in EX targets a source of the decoding instruction
    always_comb begin
        w_hazard = 1'b0;
        if (i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
            ((i_ex_rt == w_rs) || (i_ex_rt == w_rt))) begin
            w_hazard = 1'b1;
        end else begin
            w_hazard = 1'b0;
        end
    end

    // A taken branch squashes the slot, so freezing the front end is pointless
    assign o_stall = i_rst & w_hazard & ~i_flush;

    // ID/EX pipeline register; flush and stall both load a bubble
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_flush || w_hazard) begin
            r_valid         <= 1'b0;
            r_read_data_1   <= '0;
            r_read_data_2   <= '0;
            r_addr_ext      <= '0;
            r_branch_target <= '0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_rd            <= '0;
            r_wb_bus        <= '0;
            r_mem_bus       <= '0;
            r_exc_bus       <= '0;
            r_alu_op        <= '0;
            r_funct         <= '0;
        end else begin
            r_valid         <= i_valid;
            r_read_data_1   <= w_rd_data_1;
            r_read_data_2   <= w_rd_data_2;
            r_addr_ext      <= w_addr_ext;
            r_branch_target <= w_branch_target;
            r_rs            <= w_rs;
            r_rt            <= w_rt;
            r_rd            <= w_rd;
            r_wb_bus        <= w_ctrl.wb;
            r_mem_bus       <= w_ctrl.mem;
            r_exc_bus       <= w_ctrl.exc;
            r_alu_op        <= w_ctrl.alu_op;
            r_funct         <= i_valid ? w_funct : '0;
        end
    end

    assign o_valid         = r_valid;
    assign o_read_data_1   = r_read_data_1;
    assign o_read_data_2   = r_read_data_2;
    assign o_addr_ext      = r_addr_ext;
    assign o_branch_target = r_branch_target;
    assign o_rs            = r_rs;
    assign o_rt            = r_rt;
    assign o_rd            = r_rd;
    assign o_wb_bus        = r_wb_bus;
    assign o_mem_bus       = r_mem_bus;
    assign o_exc_bus       = r_exc_bus;
    assign o_alu_op        = r_alu_op;
    assign o_funct         = r_funct;

endmodule

// File: tb/tb_seg_instruction_decode_hz.sv
// Scoreboard bench for seg_instruction_decode_hz: directed cases followed by
// randomized traffic checked against an instruction-level reference model.
module tb_seg_instruction_decode_hz;

    logic        clk = 1'b0;
    logic        rst, valid, wb_en, ex_mr, flush;
    logic [31:0] instr, pc, wb_data;
    logic [4:0]  wb_addr, ex_rt;

    logic        stall, o_valid;
    logic [31:0] rd1, rd2, ext, bt;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  wb, aluop;
    logic [2:0]  mem, exc;
    logic [5:0]  funct;

    typedef struct {
        logic        valid;
        logic [31:0] rd1, rd2, ext, bt;
        logic [4:0]  rs, rt, rd;
        logic [9:0]  ctrl;
        logic [5:0]  funct;
        bit          chk_data;
        bit          chk_funct;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    int          errors = 0;
    int          checks = 0;

    seg_instruction_decode_hz dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_instruc(instr),
        .i_pc_plus4(pc), .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_ex_mem_read(ex_mr), .i_ex_rt(ex_rt), .i_flush(flush), .o_stall(stall),
        .o_valid(o_valid), .o_read_data_1(rd1), .o_read_data_2(rd2),
        .o_addr_ext(ext), .o_branch_target(bt), .o_rs(rs), .o_rt(rt), .o_rd(rd),
        .o_wb_bus(wb), .o_mem_bus(mem), .o_exc_bus(exc), .o_alu_op(aluop),
        .o_funct(funct)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Control table {wb, mem, exc, alu_op} straight from the opcode list
    function automatic logic [9:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:                      return 10'b10_000_100_10;
            6'h23:                      return 10'b11_010_010_00;
            6'h2B:                      return 10'b00_001_010_00;
            6'h04, 6'h05:               return 10'b00_100_000_01;
            6'h08, 6'h0A, 6'h0C,
            6'h0D, 6'h0E:               return 10'b10_000_010_11;
            6'h0F:                      return 10'b10_000_011_11;
            default:                    return 10'b0;
        endcase
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    // Apply current inputs for one clock: predict, push, check stall, advance
    task automatic step();
        exp_t        e;
        logic [5:0]  op;
        logic [4:0]  s, t;
        logic [15:0] imm;
        logic        haz;
        int          simm;
        op = instr[31:26]; s = instr[25:21]; t = instr[20:16]; imm = instr[15:0];
        simm = int'($signed(imm));
        haz = valid && ex_mr && ex_rt != 5'd0 && (ex_rt == s || ex_rt == t);
        e = '{valid: 1'b0, rd1: 32'd0, rd2: 32'd0, ext: 32'd0, bt: 32'd0,
              rs: 5'd0, rt: 5'd0, rd: 5'd0, ctrl: 10'd0, funct: 6'd0,
              chk_data: 1'b1, chk_funct: 1'b1};
        if (rst && (flush || haz)) begin
            e.chk_data = 1'b0;
            e.chk_funct = 1'b0;
        end else if (rst) begin
            e.valid = valid;
            e.rd1 = read_reg(s);
            e.rd2 = read_reg(t);
            if (op == 6'h0F) e.ext = 32'(imm) * 32'd65536;
            else if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e.ext = 32'(imm);
            else e.ext = 32'(simm);
            e.bt = pc + 32'(simm * 4);
            e.rs = s; e.rt = t; e.rd = instr[15:11];
            e.ctrl = valid ? ctrl_of(op) : 10'd0;
            e.funct = instr[5:0];
            e.chk_funct = valid;
        end
        q.push_back(e);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (wb_en && wb_addr != 5'd0) begin
            m_regs[wb_addr] = wb_data;
        end
        #1;
        chk("stall", {31'd0, stall}, {31'd0, rst && haz && !flush});
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] p);
        rst = 1'b1; valid = v; instr = ins; pc = p;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        ex_mr = 1'b0; ex_rt = 5'd0; flush = 1'b0;
    endtask

    // Monitor: the ID/EX register presents a new entry after every edge
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("o_valid", {31'd0, o_valid}, {31'd0, e.valid});
            chk("ctrl", {22'd0, wb, mem, exc, aluop}, {22'd0, e.ctrl});
            if (e.chk_funct) chk("o_funct", {26'd0, funct}, {26'd0, e.funct});
            if (e.chk_data) begin
                chk("read_data_1", rd1, e.rd1);
                chk("read_data_2", rd2, e.rd2);
                chk("addr_ext", ext, e.ext);
                chk("branch_target", bt, e.bt);
                chk("rs_rt_rd", {17'd0, rs, rt, rd}, {17'd0, e.rs, e.rt, e.rd});
            end
        end
    end

    initial begin
        logic [5:0] ops [13];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A,
                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h09, 6'h3F};
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        // Reset state
        set_in(1'b1, 32'h01094020, 32'h4); rst = 1'b0; step();
        // Write-back then decode
        set_in(1'b0, 32'h0, 32'h0); wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000abcd; step();
        set_in(1'b0, 32'h0, 32'h0); wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h00000011; step();
        set_in(1'b1, 32'h01094020, 32'h8); step();
        // LW and extension cases
        set_in(1'b1, 32'h8c034020, 32'hC); step();
        set_in(1'b1, 32'h2008FFFB, 32'h10); step();
        set_in(1'b1, 32'h3508FFFF, 32'h14); step();
        set_in(1'b1, 32'h3C081234, 32'h18); step();
        set_in(1'b1, 32'h10080005, 32'h100); step();
        // Load-use stall, then ex_rt=0, then flush with hazard
        set_in(1'b1, 32'h00634020, 32'h20); ex_mr = 1'b1; ex_rt = 5'd3; step();
        set_in(1'b1, 32'h00634020, 32'h20); ex_mr = 1'b1; ex_rt = 5'd0; step();
        set_in(1'b1, 32'h00634020, 32'h24); ex_mr = 1'b1; ex_rt = 5'd3; flush = 1'b1; step();
        set_in(1'b0, 32'h00634020, 32'h24); ex_mr = 1'b1; ex_rt = 5'd3; step();
        // Same-cycle bypass, reg 0 write, write during hazard
        set_in(1'b1, 32'h01294020, 32'h28); wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h5; step();
        set_in(1'b1, 32'h00004020, 32'h2C); wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h77; step();
        set_in(1'b1, 32'h014A4020, 32'h30); wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hCAFE0001;
        ex_mr = 1'b1; ex_rt = 5'd10; step();
        set_in(1'b1, 32'h014A4020, 32'h30); step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            ins = {ops[$urandom_range(0, 12)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 16'($urandom)};
            set_in($urandom_range(0, 9) != 0, ins, $urandom);
            rst = ($urandom_range(0, 99) != 0);
            wb_en = $urandom_range(0, 1);
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            ex_mr = ($urandom_range(0, 3) == 0);
            ex_rt = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 9) == 0);
            step();
        end

        // Reset mid-stream clears the bank
        set_in(1'b1, 32'h0, 32'h0); wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234; step();
        set_in(1'b1, 32'h01094020, 32'h40); step();
        set_in(1'b1, 32'h01094020, 32'h44); rst = 1'b0; wb_en = 1'b1; wb_addr = 5'd8;
        wb_data = 32'h9999; step();
        set_in(1'b1, 32'h01084020, 32'h48); step();

        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
